// File: rtl/stream_window_colorspace_converter.sv
// RGB raster to grayscale, then a sliding NxN grayscale window built from N-1 internal line buffers.
// Two-stage pipeline: stage 1 converts and tags coordinates, stage 2 updates the window and emits it.
module stream_window_colorspace_converter #(
  parameter int P_FRAME_COLUMNS      = 640,
  parameter int P_FRAME_ROWS         = 480,
  parameter int P_PIXEL_DEPTH        = 24,
  parameter int P_OUTPUT_MATRIX_SIZE = 3,
  parameter int P_GRAY_MODE          = 0
) (
  input  logic                                        I_CLK,
  input  logic                                        I_RESET,
  input  logic                                        I_ENABLE,
  input  logic                                        I_PIXEL_VALID,
  input  logic [P_PIXEL_DEPTH-1:0]                    I_PIXEL,
  input  logic                                        I_VSYNC,
  input  logic                                        I_DATA_ENABLE,
  output logic [$clog2(P_FRAME_COLUMNS)-1:0]          O_PIXEL_COLUMN,
  output logic [$clog2(P_FRAME_ROWS)-1:0]             O_PIXEL_ROW,
  output logic [P_OUTPUT_MATRIX_SIZE*P_OUTPUT_MATRIX_SIZE*(P_PIXEL_DEPTH/3)-1:0] O_PIXEL_MATRIX,
  output logic                                        O_PIXEL_MATRIX_READY
);
  localparam int N     = P_OUTPUT_MATRIX_SIZE;
  localparam int D     = P_PIXEL_DEPTH / 3;
  localparam int COL_W = $clog2(P_FRAME_COLUMNS);
  localparam int ROW_W = $clog2(P_FRAME_ROWS);
  localparam int ACC_W = D + 10;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(P_FRAME_COLUMNS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(P_FRAME_ROWS - 1);
  localparam logic [COL_W-1:0] EDGE_COL = COL_W'(N - 1);
  localparam logic [ROW_W-1:0] EDGE_ROW = ROW_W'(N - 1);

  function automatic logic [D-1:0] to_gray(input logic [P_PIXEL_DEPTH-1:0] px);
    logic [ACC_W-1:0] r, g, b, acc;
    r = ACC_W'(px[P_PIXEL_DEPTH-1 -: D]);
    g = ACC_W'(px[2*D-1 -: D]);
    b = ACC_W'(px[D-1:0]);
    if (P_GRAY_MODE == 0) acc = ((r + g + b) * ACC_W'(171)) >> 9;
    else                  acc = (r * ACC_W'(77) + g * ACC_W'(150) + b * ACC_W'(29)) >> 8;
    return acc[D-1:0];
  endfunction

  logic             vsync_q, vsync_d;
  logic [COL_W-1:0] col_q, col_d, col_cur;
  logic [ROW_W-1:0] row_q, row_d, row_cur;
  logic             vld_p1_q, vld_p1_d;
  logic [D-1:0]     gray_p1_q, gray_p1_d;
  logic [COL_W-1:0] col_p1_q, col_p1_d;
  logic [ROW_W-1:0] row_p1_q, row_p1_d;
  logic [D-1:0]     rd_p1 [N-1];
  logic [D-1:0]     win_q [N][N];
  logic [D-1:0]     win_d [N][N];
  logic [D-1:0]     line_buf_q [N-1][P_FRAME_COLUMNS];
  logic             ready_q, ready_d;
  logic [COL_W-1:0] ocol_q, ocol_d;
  logic [ROW_W-1:0] orow_q, orow_d;
  logic [N*N*D-1:0] mat_q, mat_d;
  logic             beat, vsync_rise, proc_p1;

  assign beat       = I_ENABLE & I_PIXEL_VALID & I_DATA_ENABLE;
  assign vsync_rise = I_VSYNC & ~vsync_q;
  // A pixel still in stage 1 is discarded when the frame restarts or the block is disabled.
  assign proc_p1    = vld_p1_q & I_ENABLE & ~vsync_rise;

  // Stage 0 -> 1: coordinate tracking and grayscale conversion
  always_comb begin
    vsync_d   = I_VSYNC;
    col_cur   = vsync_rise ? '0 : col_q;
    row_cur   = vsync_rise ? '0 : row_q;
    col_d     = col_cur;
    row_d     = row_cur;
    vld_p1_d  = 1'b0;
    gray_p1_d = gray_p1_q;
    col_p1_d  = col_p1_q;
    row_p1_d  = row_p1_q;
    if (beat) begin
      vld_p1_d  = 1'b1;
      gray_p1_d = to_gray(I_PIXEL);
      col_p1_d  = col_cur;
      row_p1_d  = row_cur;
      if (col_cur == LAST_COL) begin
        col_d = '0;
        row_d = (row_cur == LAST_ROW) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N - 1; k++) rd_p1[k] = line_buf_q[k][col_p1_q];
  end

  // Stage 1 -> 2: window shift and output capture
  always_comb begin
    win_d   = win_q;
    ready_d = 1'b0;
    ocol_d  = ocol_q;
    orow_d  = orow_q;
    mat_d   = mat_q;
    if (proc_p1) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N - 1; c++) win_d[r][c] = win_q[r][c+1];
      for (int r = 0; r < N - 1; r++) win_d[r][N-1] = rd_p1[N-2-r];
      win_d[N-1][N-1] = gray_p1_q;
      if (row_p1_q >= EDGE_ROW && col_p1_q >= EDGE_COL) begin
        ready_d = 1'b1;
        ocol_d  = col_p1_q - EDGE_COL;
        orow_d  = row_p1_q - EDGE_ROW;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) mat_d[(r*N+c)*D +: D] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      vsync_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      vld_p1_q <= 1'b0;
      win_q    <= '{default: '0};
      ready_q  <= 1'b0;
      ocol_q   <= '0;
      orow_q   <= '0;
      mat_q    <= '0;
    end else begin
      vsync_q  <= vsync_d;
      col_q    <= col_d;
      row_q    <= row_d;
      vld_p1_q <= vld_p1_d;
      win_q    <= win_d;
      ready_q  <= ready_d;
      ocol_q   <= ocol_d;
      orow_q   <= orow_d;
      mat_q    <= mat_d;
    end
  end

  // Datapath storage; validity is carried by vld_p1_q and the row counter, so no reset here.
  always_ff @(posedge I_CLK) begin
    gray_p1_q <= gray_p1_d;
    col_p1_q  <= col_p1_d;
    row_p1_q  <= row_p1_d;
    if (proc_p1) begin
      line_buf_q[0][col_p1_q] <= gray_p1_q;
      for (int k = 0; k < N - 2; k++) line_buf_q[k+1][col_p1_q] <= rd_p1[k];
    end
  end

  assign O_PIXEL_COLUMN       = ocol_q;
  assign O_PIXEL_ROW          = orow_q;
  assign O_PIXEL_MATRIX       = mat_q;
  assign O_PIXEL_MATRIX_READY = ready_q;

endmodule

// File: tb/tb_stream_window_colorspace_converter.sv
// Bench for stream_window_colorspace_converter: two 8x4 N=3 instances (both gray modes) share one
// stream, a 16x8 N=5 instance has its own; a frame-store model predicts every window.
module tb_stream_window_colorspace_converter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_en = 0, a_pv = 0, a_de = 0, a_vs = 0;
  logic b_en = 0, b_pv = 0, b_de = 0, b_vs = 0;
  logic [23:0] a_px = '0, b_px = '0;
  logic [2:0]  a0_col, a1_col;
  logic [1:0]  a0_row, a1_row;
  logic [71:0] a0_mat, a1_mat;
  logic        a0_rdy, a1_rdy;
  logic [3:0]  b_col;
  logic [2:0]  b_row;
  logic [199:0] b_mat;
  logic        b_rdy;

  int n_chk = 0, n_fail = 0;

  // Model state, index 0 = 8x4 stream, 1 = 16x8 stream
  int COLS[2] = '{8, 16};
  int ROWS[2] = '{4, 8};
  int NN[2]   = '{3, 5};
  logic [7:0] fr0 [2][8][16];
  logic [7:0] fr1 [8][16];
  int mrow[2] = '{0, 0}, mcol[2] = '{0, 0}, pr[2] = '{0, 0}, pc[2] = '{0, 0};
  bit pend[2] = '{0, 0}, vsl[2] = '{0, 0};
  bit exp_rdy[2];
  int exp_col[2], exp_row[2];
  logic [199:0] exp_m0 [2];
  logic [71:0]  exp_m1;

  always #5 clk = ~clk;

  stream_window_colorspace_converter #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(4), .P_PIXEL_DEPTH(24),
    .P_OUTPUT_MATRIX_SIZE(3), .P_GRAY_MODE(0)) dut_a0 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(a_en), .I_PIXEL_VALID(a_pv), .I_PIXEL(a_px),
    .I_VSYNC(a_vs), .I_DATA_ENABLE(a_de), .O_PIXEL_COLUMN(a0_col), .O_PIXEL_ROW(a0_row),
    .O_PIXEL_MATRIX(a0_mat), .O_PIXEL_MATRIX_READY(a0_rdy));

  stream_window_colorspace_converter #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(4), .P_PIXEL_DEPTH(24),
    .P_OUTPUT_MATRIX_SIZE(3), .P_GRAY_MODE(1)) dut_a1 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(a_en), .I_PIXEL_VALID(a_pv), .I_PIXEL(a_px),
    .I_VSYNC(a_vs), .I_DATA_ENABLE(a_de), .O_PIXEL_COLUMN(a1_col), .O_PIXEL_ROW(a1_row),
    .O_PIXEL_MATRIX(a1_mat), .O_PIXEL_MATRIX_READY(a1_rdy));

  stream_window_colorspace_converter #(.P_FRAME_COLUMNS(16), .P_FRAME_ROWS(8), .P_PIXEL_DEPTH(24),
    .P_OUTPUT_MATRIX_SIZE(5), .P_GRAY_MODE(0)) dut_b (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(b_en), .I_PIXEL_VALID(b_pv), .I_PIXEL(b_px),
    .I_VSYNC(b_vs), .I_DATA_ENABLE(b_de), .O_PIXEL_COLUMN(b_col), .O_PIXEL_ROW(b_row),
    .O_PIXEL_MATRIX(b_mat), .O_PIXEL_MATRIX_READY(b_rdy));

  function automatic logic [7:0] gray(input int mode, input logic [23:0] px);
    int r, g, b;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
    if (mode == 0) return 8'(((r + g + b) * 171) / 512);
    return 8'((77 * r + 150 * g + 29 * b) / 256);
  endfunction

  function automatic logic [23:0] rgb(input int v);
    logic [7:0] c;
    c = 8'(v);
    return {c, c, c};
  endfunction

  // Drive one cycle on stream s (the other stream idles) and advance the frame-store model.
  task automatic step(input int s, input bit en, input bit pv, input bit de, input bit vs,
                      input logic [23:0] px);
    bit e, p, d, v, beat, rise;
    int r0, c0;
    if (s == 0) begin
      a_en = en; a_pv = pv; a_de = de; a_vs = vs; a_px = px;
      b_en = 0;  b_pv = 0;  b_de = 0;  b_vs = 0;
    end else begin
      b_en = en; b_pv = pv; b_de = de; b_vs = vs; b_px = px;
      a_en = 0;  a_pv = 0;  a_de = 0;  a_vs = 0;
    end
    for (int t = 0; t < 2; t++) begin
      e = (t == s) ? en : 1'b0;
      p = (t == s) ? pv : 1'b0;
      d = (t == s) ? de : 1'b0;
      v = (t == s) ? vs : 1'b0;
      beat = e & p & d;
      rise = v & ~vsl[t];
      exp_rdy[t] = 1'b0;
      if (!rst && pend[t] && e && !rise && pr[t] >= NN[t] - 1 && pc[t] >= NN[t] - 1) begin
        exp_rdy[t] = 1'b1;
        r0 = pr[t] - (NN[t] - 1);
        c0 = pc[t] - (NN[t] - 1);
        exp_row[t] = r0;
        exp_col[t] = c0;
        exp_m0[t] = '0;
        if (t == 0) exp_m1 = '0;
        for (int i = 0; i < NN[t]; i++)
          for (int j = 0; j < NN[t]; j++) begin
            exp_m0[t][(i*NN[t]+j)*8 +: 8] = fr0[t][r0+i][c0+j];
            if (t == 0) exp_m1[(i*3+j)*8 +: 8] = fr1[r0+i][c0+j];
          end
      end
      if (rst) begin
        mrow[t] = 0; mcol[t] = 0; pend[t] = 0; vsl[t] = 0;
      end else begin
        vsl[t] = v;
        if (rise) begin mrow[t] = 0; mcol[t] = 0; end
        pend[t] = beat;
        if (beat) begin
          pr[t] = mrow[t];
          pc[t] = mcol[t];
          fr0[t][mrow[t]][mcol[t]] = gray(0, px);
          if (t == 0) fr1[mrow[t]][mcol[t]] = gray(1, px);
          mcol[t]++;
          if (mcol[t] == COLS[t]) begin
            mcol[t] = 0;
            mrow[t]++;
            if (mrow[t] == ROWS[t]) mrow[t] = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, 0, 24'($urandom));
      n_chk++;
      if ({a0_rdy, a0_col, a0_row, a0_mat, a1_rdy, a1_col, a1_row, a1_mat} !== '0) begin
        n_fail++;
        $display("FAIL reset_a got rdy=%0b col=%0d row=%0d mat=%h / mode1 mat=%h, required all zero",
                 a0_rdy, a0_col, a0_row, a0_mat, a1_mat);
      end
      n_chk++;
      if ({b_rdy, b_col, b_row, b_mat} !== '0) begin
        n_fail++;
        $display("FAIL reset_b got rdy=%0b col=%0d row=%0d mat=%h, required all zero",
                 b_rdy, b_col, b_row, b_mat);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_gray_modes();
    logic [23:0] colors [3];
    int cnt0, cnt1;
    colors = '{24'h1E3C5A, 24'hFF0000, 24'hFFFFFF};
    for (int k = 0; k < 3; k++) begin
      cnt0 = 0; cnt1 = 0;
      for (int p = 0; p < 33; p++) begin
        if (p < 32) step(0, 1, 1, 1, p == 0, colors[k]);
        else        step(0, 1, 0, 1, 0, 24'h0);
        n_chk++;
        if (a0_rdy !== exp_rdy[0] || (exp_rdy[0] &&
            {a0_col, a0_row, a0_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m0[0][71:0]})) begin
          n_fail++;
          $display("FAIL gray_win_m0 got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                   a0_rdy, a0_col, a0_row, a0_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m0[0][71:0]);
        end
        n_chk++;
        if (a1_rdy !== exp_rdy[0] || (exp_rdy[0] &&
            {a1_col, a1_row, a1_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m1})) begin
          n_fail++;
          $display("FAIL gray_win_m1 got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                   a1_rdy, a1_col, a1_row, a1_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m1);
        end
        cnt0 += int'(a0_rdy);
        cnt1 += int'(a1_rdy);
      end
      n_chk++;
      if (cnt0 != 12 || cnt1 != 12) begin
        n_fail++;
        $display("FAIL gray_pulses got %0d/%0d required 12/12", cnt0, cnt1);
      end
      n_chk++;
      if ((k == 0 && a0_mat[7:0] !== 8'd60) || (k == 1 && a1_mat[7:0] !== 8'd76) ||
          (k == 2 && (a0_mat[7:0] !== 8'd255 || a1_mat[7:0] !== 8'd255))) begin
        n_fail++;
        $display("FAIL gray_const color=%h got m0=%0d m1=%0d required %s", colors[k],
                 a0_mat[7:0], a1_mat[7:0], k == 0 ? "m0=60" : (k == 1 ? "m1=76" : "m0=m1=255"));
      end
    end
  endtask

  task automatic test_raster();
    int cnt, first_idx, lc, lr, fc, fr;
    logic [71:0] first_ref, first_mat;
    first_ref = {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0};
    cnt = 0; first_idx = -1; lc = -1; lr = -1; fc = -1; fr = -1; first_mat = '0;
    for (int idx = 0; idx < 33; idx++) begin
      if (idx < 32) step(0, 1, 1, 1, idx == 0, rgb((idx / 8) * 16 + idx % 8));
      else          step(0, 1, 0, 1, 0, 24'h0);
      n_chk++;
      if (a0_rdy !== exp_rdy[0] || (exp_rdy[0] &&
          {a0_col, a0_row, a0_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m0[0][71:0]})) begin
        n_fail++;
        $display("FAIL raster_win_m0 got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                 a0_rdy, a0_col, a0_row, a0_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m0[0][71:0]);
      end
      n_chk++;
      if (a1_rdy !== exp_rdy[0] || (exp_rdy[0] &&
          {a1_col, a1_row, a1_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m1})) begin
        n_fail++;
        $display("FAIL raster_win_m1 got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                 a1_rdy, a1_col, a1_row, a1_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m1);
      end
      if (a0_rdy === 1'b1) begin
        cnt++; lc = int'(a0_col); lr = int'(a0_row);
        if (first_idx < 0) begin first_idx = idx; first_mat = a0_mat; fc = lc; fr = lr; end
      end
    end
    n_chk++;
    if (first_idx != 19) begin
      n_fail++;
      $display("FAIL raster_latency first ready at step %0d required 19 (beat (2,2) at 18)", first_idx);
    end
    n_chk++;
    if (first_mat !== first_ref || fc != 0 || fr != 0) begin
      n_fail++;
      $display("FAIL raster_first got mat=%h col=%0d row=%0d required mat=%h col=0 row=0",
               first_mat, fc, fr, first_ref);
    end
    n_chk++;
    if (cnt != 12 || lc != 5 || lr != 1) begin
      n_fail++;
      $display("FAIL raster_count got %0d pulses last col=%0d row=%0d required 12, col=5 row=1", cnt, lc, lr);
    end
  endtask

  task automatic test_vsync();
    int cnt, first_idx;
    logic [7:0] first_px;
    cnt = 0; first_idx = -1; first_px = '0;
    for (int idx = 0; idx < 21; idx++) begin
      step(0, 1, 1, 1, idx == 0, rgb((idx / 8) * 16 + idx % 8));
      n_chk++;
      if (a0_rdy !== exp_rdy[0] || (exp_rdy[0] &&
          {a0_col, a0_row, a0_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m0[0][71:0]})) begin
        n_fail++;
        $display("FAIL vsync_old_win got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                 a0_rdy, a0_col, a0_row, a0_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m0[0][71:0]);
      end
    end
    for (int idx = 0; idx < 33; idx++) begin
      if (idx < 32) step(0, 1, 1, 1, idx == 0, rgb(100 + (idx / 8) * 16 + idx % 8));
      else          step(0, 1, 0, 1, 0, 24'h0);
      n_chk++;
      if (a0_rdy !== exp_rdy[0] || (exp_rdy[0] &&
          {a0_col, a0_row, a0_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m0[0][71:0]})) begin
        n_fail++;
        $display("FAIL vsync_new_win_m0 got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                 a0_rdy, a0_col, a0_row, a0_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m0[0][71:0]);
      end
      n_chk++;
      if (a1_rdy !== exp_rdy[0] || (exp_rdy[0] &&
          {a1_col, a1_row, a1_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m1})) begin
        n_fail++;
        $display("FAIL vsync_new_win_m1 got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                 a1_rdy, a1_col, a1_row, a1_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m1);
      end
      if (a0_rdy === 1'b1) begin
        cnt++;
        if (first_idx < 0) begin first_idx = idx; first_px = a0_mat[7:0]; end
      end
    end
    n_chk++;
    if (first_idx != 19 || first_px !== 8'd100 || cnt != 12) begin
      n_fail++;
      $display("FAIL vsync_restart got first step=%0d first pixel=%0d pulses=%0d required 19, 100, 12",
               first_idx, first_px, cnt);
    end
  endtask

  task automatic test_gating();
    int cnt, gaps;
    bit e, p, d;
    cnt = 0;
    for (int idx = 0; idx < 33; idx++) begin
      gaps = (idx < 32) ? int'($urandom_range(0, 3)) : 1;
      for (int g = 0; g <= gaps; g++) begin
        if (g == gaps && idx < 32) begin
          step(0, 1, 1, 1, idx == 0, 24'($urandom));
        end else if (g == 0) begin
          step(0, 1, 0, 1'($urandom), 0, 24'($urandom));
        end else begin
          e = 1'($urandom); p = 1'($urandom);
          d = (e & p) ? 1'b0 : 1'($urandom);
          step(0, e, p, d, 0, 24'($urandom));
        end
        n_chk++;
        if (a0_rdy !== exp_rdy[0] || (exp_rdy[0] &&
            {a0_col, a0_row, a0_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m0[0][71:0]})) begin
          n_fail++;
          $display("FAIL gating_win_m0 got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                   a0_rdy, a0_col, a0_row, a0_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m0[0][71:0]);
        end
        n_chk++;
        if (a1_rdy !== exp_rdy[0] || (exp_rdy[0] &&
            {a1_col, a1_row, a1_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m1})) begin
          n_fail++;
          $display("FAIL gating_win_m1 got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                   a1_rdy, a1_col, a1_row, a1_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m1);
        end
        if (a0_rdy === 1'b1) begin
          n_chk++;
          if (int'(a0_col) != cnt % 6 || int'(a0_row) != cnt / 6) begin
            n_fail++;
            $display("FAIL gating_order pulse %0d got col=%0d row=%0d required col=%0d row=%0d",
                     cnt, a0_col, a0_row, cnt % 6, cnt / 6);
          end
          cnt++;
        end
      end
    end
    n_chk++;
    if (cnt != 12) begin
      n_fail++;
      $display("FAIL gating_count got %0d pulses required 12", cnt);
    end
  endtask

  task automatic test_reset_mid();
    int cnt, first_idx;
    for (int idx = 0; idx < 29; idx++) begin
      step(0, 1, 1, 1, idx == 0, rgb((idx / 8) * 16 + idx % 8));
      n_chk++;
      if (a0_rdy !== exp_rdy[0] || (exp_rdy[0] &&
          {a0_col, a0_row, a0_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m0[0][71:0]})) begin
        n_fail++;
        $display("FAIL rstmid_pre_win got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                 a0_rdy, a0_col, a0_row, a0_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m0[0][71:0]);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, 0, 24'($urandom));
      n_chk++;
      if ({a0_rdy, a0_col, a0_row, a0_mat, a1_rdy, a1_col, a1_row, a1_mat} !== '0) begin
        n_fail++;
        $display("FAIL rstmid_zero got rdy=%0b col=%0d row=%0d mat=%h / mode1 mat=%h, required all zero",
                 a0_rdy, a0_col, a0_row, a0_mat, a1_mat);
      end
    end
    rst = 1'b0;
    cnt = 0; first_idx = -1;
    for (int idx = 0; idx < 33; idx++) begin
      if (idx < 32) step(0, 1, 1, 1, 0, rgb(200 + idx));
      else          step(0, 1, 0, 1, 0, 24'h0);
      n_chk++;
      if (a0_rdy !== exp_rdy[0] || (exp_rdy[0] &&
          {a0_col, a0_row, a0_mat} !== {3'(exp_col[0]), 2'(exp_row[0]), exp_m0[0][71:0]})) begin
        n_fail++;
        $display("FAIL rstmid_post_win got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                 a0_rdy, a0_col, a0_row, a0_mat, exp_rdy[0], exp_col[0], exp_row[0], exp_m0[0][71:0]);
      end
      if (a0_rdy === 1'b1) begin
        cnt++;
        if (first_idx < 0) first_idx = idx;
      end
    end
    n_chk++;
    if (first_idx != 19 || cnt != 12) begin
      n_fail++;
      $display("FAIL rstmid_restart got first step=%0d pulses=%0d required 19, 12", first_idx, cnt);
    end
  endtask

  task automatic test_n5();
    int cnt, first_idx;
    logic [39:0] first_row;
    cnt = 0; first_idx = -1; first_row = '0;
    for (int idx = 0; idx < 129; idx++) begin
      if (idx < 128) step(1, 1, 1, 1, idx == 0, rgb((idx / 16) * 16 + idx % 16));
      else           step(1, 1, 0, 1, 0, 24'h0);
      n_chk++;
      if (b_rdy !== exp_rdy[1] || (exp_rdy[1] &&
          {b_col, b_row, b_mat} !== {4'(exp_col[1]), 3'(exp_row[1]), exp_m0[1]})) begin
        n_fail++;
        $display("FAIL n5_win got rdy=%0b col=%0d row=%0d mat=%h required rdy=%0b col=%0d row=%0d mat=%h",
                 b_rdy, b_col, b_row, b_mat, exp_rdy[1], exp_col[1], exp_row[1], exp_m0[1]);
      end
      if (b_rdy === 1'b1) begin
        cnt++;
        if (first_idx < 0) begin first_idx = idx; first_row = b_mat[39:0]; end
      end
    end
    n_chk++;
    if (cnt != (16 - 5 + 1) * (8 - 5 + 1) || first_idx != 69) begin
      n_fail++;
      $display("FAIL n5_count got %0d pulses, first at step %0d, required %0d, 69",
               cnt, first_idx, (16 - 5 + 1) * (8 - 5 + 1));
    end
    n_chk++;
    if (first_row !== {8'd4, 8'd3, 8'd2, 8'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL n5_first_row got %h required 0403020100", first_row);
    end
  endtask

  initial begin
    test_reset();
    test_gray_modes();
    test_raster();
    test_vsync();
    test_gating();
    test_reset_mid();
    test_n5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
